// File: rtl/alu_bist_pkg.sv
// Shared constants for the ALU BIST: opcodes, LFSR/MISR polynomial and seeds, FSM states.
// Pure definitions; no latency and no flow control.
package alu_bist_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] SEED_A    = 32'hACE12345;
  localparam logic [31:0] SEED_B    = 32'h13579BDF;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Left-shifting Galois step; the MISR uses the same feedback before folding in data.
  function automatic logic [31:0] galois_step(input logic [31:0] v);
    return {v[30:0], 1'b0} ^ (v[31] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [4:0] next_op(input logic [4:0] op);
    logic [4:0] n;
    case (op)
      OP_ADD:  n = OP_SUB;
      OP_SUB:  n = OP_AND;
      OP_AND:  n = OP_OR;
      OP_OR:   n = OP_SLL;
      OP_SLL:  n = OP_SRA;
      default: n = OP_ADD;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit Galois LFSR pattern source; load has priority over advance.
// New value visible one cycle after load/advance; no backpressure.
module bist_lfsr32
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= galois_step(state);
    end
  end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test: drives LFSR operands and cycling opcodes, compacts responses into a MISR.
// Two cycles per vector (drive, capture); start ignored while busy, abort wins over start.
module alu_bist
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] num_vectors,
  input  logic [31:0] golden_sig,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic [4:0]  ctrl_ALUopcode,
  output logic [4:0]  ctrl_shiftamt,
  input  logic [31:0] data_result,
  input  logic        isNotEqual,
  input  logic        isLessThan,
  input  logic        overflow,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [15:0] vec_count
);

  state_t      state;
  logic [15:0] num_q;
  logic [31:0] golden_q;
  logic        start_ok;
  logic        advance;
  logic        last_vec;
  logic        is_add_sub;
  logic        is_sub;
  logic [31:0] flag_word;
  logic [31:0] sig_next;

  assign start_ok = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign advance  = (state == ST_CAPTURE) && !abort;

  bist_lfsr32 u_lfsr_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_ok),
    .seed    (SEED_A),
    .advance (advance),
    .state   (data_operandA)
  );

  bist_lfsr32 u_lfsr_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_ok),
    .seed    (SEED_B),
    .advance (advance),
    .state   (data_operandB)
  );

  assign ctrl_shiftamt = data_operandB[4:0];

  // Flags only carry meaning for the ops that define them; mask the rest so a
  // don't-care ALU flag cannot perturb the signature.
  assign is_add_sub = (ctrl_ALUopcode == OP_ADD) || (ctrl_ALUopcode == OP_SUB);
  assign is_sub     = (ctrl_ALUopcode == OP_SUB);
  assign flag_word  = {29'd0, overflow & is_add_sub, isLessThan & is_sub, isNotEqual & is_sub};
  assign sig_next   = galois_step(signature) ^ data_result ^ flag_word;

  // 17-bit compare so num_vectors = 0xFFFF terminates without the count wrapping.
  assign last_vec = ({1'b0, vec_count} + 17'd1) >= {1'b0, num_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ctrl_ALUopcode <= OP_ADD;
      signature      <= MISR_SEED;
      vec_count      <= '0;
      num_q          <= '0;
      golden_q       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_q          <= num_vectors;
            golden_q       <= golden_sig;
            signature      <= MISR_SEED;
            vec_count      <= '0;
            ctrl_ALUopcode <= OP_ADD;
            if (num_vectors == 16'd0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (golden_sig == MISR_SEED);
            end else begin
              state <= ST_DRIVE;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        ST_DRIVE: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          signature      <= sig_next;
          vec_count      <= vec_count + 16'd1;
          ctrl_ALUopcode <= next_op(ctrl_ALUopcode);
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next == golden_q);
          end else begin
            state <= ST_DRIVE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU, vector-level reference model, per-cycle compare.
module tb_alu_bist;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [15:0] num_vectors;
  logic [31:0] golden_sig;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic [4:0]  ctrl_ALUopcode, ctrl_shiftamt;
  logic        isNotEqual, isLessThan, overflow;
  logic        busy, done, pass;
  logic [31:0] signature;
  logic [15:0] vec_count;
  bit          alu_fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_vectors(num_vectors), .golden_sig(golden_sig),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
    .data_result(data_result), .isNotEqual(isNotEqual), .isLessThan(isLessThan),
    .overflow(overflow), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .vec_count(vec_count)
  );

  // Returns {overflow, isLessThan, isNotEqual, result}; fault forces result bit 0 low.
  function automatic logic [34:0] alu_f(input int op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sh, input bit flt);
    logic [31:0] r;
    logic        ovf;
    r = 32'h0;
    ovf = 1'b0;
    case (op)
      0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      2: r = a & b;
      3: r = a | b;
      4: r = a << sh;
      5: r = $signed(a) >>> sh;
      default: r = 32'h0;
    endcase
    if (flt) r[0] = 1'b0;
    return {ovf, ($signed(a) < $signed(b)), (a != b), r};
  endfunction

  always_comb begin
    {overflow, isLessThan, isNotEqual, data_result} =
      alu_f(int'(ctrl_ALUopcode), data_operandA, data_operandB, ctrl_shiftamt, alu_fault);
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v << 1) ^ (v[31] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] s, input int i, input logic [31:0] a,
                                            input logic [31:0] b, input bit flt);
    logic [34:0] r;
    logic [31:0] fw;
    int op;
    op = i % 6;
    r  = alu_f(op, a, b, b[4:0], flt);
    fw = 32'h0;
    fw[2] = r[34] && (op == 0 || op == 1);
    fw[1] = r[33] && (op == 1);
    fw[0] = r[32] && (op == 1);
    return (s << 1) ^ (s[31] ? 32'h80200003 : 32'h0) ^ r[31:0] ^ fw;
  endfunction

  function automatic logic [31:0] golden_of(input int n);
    logic [31:0] a, b, s;
    a = 32'hACE12345; b = 32'h13579BDF; s = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      s = misr_next(s, i, a, b, 1'b0);
      a = lfsr_next(a);
      b = lfsr_next(b);
    end
    return s;
  endfunction

  // Model: ma/mb/msig[i] are operands and signature seen while vector i is in flight.
  logic [31:0] ma[$], mb[$], msig[$];
  int          m_mode;   // 0 reset values, 1 idle after abort, 2 running, 3 done
  int          m_k, m_n;
  logic [31:0] m_golden;

  task automatic build_model(input int n, input bit flt);
    logic [31:0] a, b, s;
    ma.delete(); mb.delete(); msig.delete();
    a = 32'hACE12345; b = 32'h13579BDF; s = 32'hFFFFFFFF;
    for (int i = 0; i <= n; i++) begin
      ma.push_back(a); mb.push_back(b); msig.push_back(s);
      if (i < n) begin
        s = misr_next(s, i, a, b, flt);
        a = lfsr_next(a);
        b = lfsr_next(b);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    m_mode = 0; m_k = 0; m_n = 0; m_golden = 32'h0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0;
      end else if (abort) begin
        m_mode = 1;
      end else if (start && m_mode != 2) begin
        m_n = int'(num_vectors);
        m_golden = golden_sig;
        build_model(m_n, alu_fault);
        m_k = 0;
        m_mode = (m_n == 0) ? 3 : 2;
      end else if (m_mode == 2) begin
        m_k++;
        if (m_k == 2 * m_n) m_mode = 3;
      end
    end
  end

  initial begin
    int v;
    forever begin
      @(negedge clk);
      case (m_mode)
        0: begin
          chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
          chk("rst_sig", signature, 32'hFFFFFFFF); chk("rst_cnt", vec_count, 0);
          chk("rst_a", data_operandA, 0); chk("rst_b", data_operandB, 0);
          chk("rst_op", ctrl_ALUopcode, 0); chk("rst_sh", ctrl_shiftamt, 0);
        end
        1: begin
          chk("idle_busy", busy, 0); chk("idle_done", done, 0); chk("idle_pass", pass, 0);
        end
        2: begin
          v = m_k / 2;
          chk("run_busy", busy, 1); chk("run_done", done, 0); chk("run_pass", pass, 0);
          chk("run_cnt", vec_count, v); chk("run_sig", signature, msig[v]);
          chk("run_a", data_operandA, ma[v]); chk("run_b", data_operandB, mb[v]);
          chk("run_op", ctrl_ALUopcode, v % 6); chk("run_sh", ctrl_shiftamt, mb[v][4:0]);
        end
        default: begin
          chk("end_busy", busy, 0); chk("end_done", done, 1);
          chk("end_pass", pass, (msig[m_n] == m_golden) ? 1 : 0);
          chk("end_cnt", vec_count, m_n); chk("end_sig", signature, msig[m_n]);
          chk("end_a", data_operandA, ma[m_n]); chk("end_op", ctrl_ALUopcode, m_n % 6);
        end
      endcase
    end
  end

  task automatic start_pulse(input logic [15:0] n, input logic [31:0] g);
    @(negedge clk);
    start = 1'b1; num_vectors = n; golden_sig = g;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, done, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_vectors = 16'd0; golden_sig = 32'h0;
    alu_fault = 1'b0;

    build_model(2, 1'b0);
    chk("pin_a0", ma[0], 32'hACE12345);
    chk("pin_b0", mb[0], 32'h13579BDF);
    chk("pin_a1", ma[1], 32'hD9E24689);
    chk("pin_b1", mb[1], 32'h26AF37BE);
    chk("pin_sig1", msig[1], 32'hBFE740D9);
    chk("pin_golden1", golden_of(1), 32'hBFE740D9);

    repeat (3) @(negedge clk);
    chk("reset_sig", signature, 32'hFFFFFFFF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-length run completes on the accepting edge.
    start_pulse(16'd0, 32'hFFFFFFFF);
    chk("zero_done", done, 1); chk("zero_pass", pass, 1); chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_hold", done, 1);

    // Single vector against the behavioural ALU.
    start_pulse(16'd1, 32'hBFE740D9);
    chk("one_a", data_operandA, 32'hACE12345); chk("one_b", data_operandB, 32'h13579BDF);
    chk("one_op", ctrl_ALUopcode, 0); chk("one_sh", ctrl_shiftamt, 5'h1F);
    chk("one_res", data_result, 32'hC038BF24); chk("one_ovf", overflow, 0);
    @(negedge clk);
    chk("one_capbusy", busy, 1);
    @(negedge clk);
    chk("one_done", done, 1); chk("one_sig", signature, 32'hBFE740D9); chk("one_pass", pass, 1);

    // Twelve vectors with a stray start mid-run, then the same run with a faulty ALU.
    g = golden_of(12);
    start_pulse(16'd12, g);
    repeat (5) @(negedge clk);
    start = 1'b1; num_vectors = 16'd3; golden_sig = 32'h0;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, "run12_done");
    chk("run12_pass", pass, 1); chk("run12_sig", signature, g);
    alu_fault = 1'b1;
    start_pulse(16'd12, g);
    wait_done(40, "fault_done");
    chk("fault_pass", pass, 0);
    alu_fault = 1'b0;

    // Abort during vector 5 of 12 with a simultaneous start; abort must win.
    start_pulse(16'd12, g);
    repeat (8) @(negedge clk);
    chk("abort_pre_cnt", vec_count, 4);
    abort = 1'b1; start = 1'b1; num_vectors = 16'd12; golden_sig = g;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_stay_idle", busy, 0);
    start_pulse(16'd12, g);
    wait_done(40, "rerun_done");
    chk("rerun_sig", signature, g); chk("rerun_pass", pass, 1);

    // Asynchronous reset mid-run, between clock edges.
    start_pulse(16'd12, g);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_sig", signature, 32'hFFFFFFFF);
    chk("arst_cnt", vec_count, 0); chk("arst_a", data_operandA, 0);
    chk("arst_op", ctrl_ALUopcode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst_no_done", done, 0);

    // Longer run exercising the counter well past the opcode period.
    start_pulse(16'd1500, golden_of(1500));
    wait_done(3100, "long_done");
    chk("long_cnt", vec_count, 16'd1500); chk("long_pass", pass, 1);

    // Random windows: random length, golden, fault, stray starts and aborts.
    for (int w = 0; w < 10; w++) begin
      int n;
      n = $urandom_range(0, 24);
      alu_fault = ($urandom_range(0, 3) == 0);
      start_pulse(16'(n), ($urandom_range(0, 1) == 1) ? golden_of(n) : $urandom);
      for (int c = 0; c < 2 * n + 6; c++) begin
        int r;
        r = $urandom_range(0, 99);
        abort = (r < 3);
        start = (r < 2) || (r >= 3 && r < 10);
        num_vectors = 16'($urandom_range(0, 20));
        golden_sig = $urandom;
        @(negedge clk);
      end
      abort = 1'b0; start = 1'b0;
      repeat (50) @(negedge clk);
    end
    alu_fault = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 SHALL: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  one clock; reset is asynchronous and active-low.
REQ-003 SHALL: start  in  1  one-cycle pulse, begins a run when in IDLE or DONE.
REQ-004 SHALL: abort  in  1  level, terminates a run and returns to IDLE.
REQ-005 SHALL: num_vectors  in  16  vectors per run, sampled on accepted start.
REQ-006 SHALL: golden_sig  in  32  expected final signature, sampled on accepted start.
REQ-007 SHALL: data_operandA, data_operandB  out  32 each  operands to ALU.
REQ-008 SHALL: ctrl_ALUopcode, ctrl_shiftamt  out  5 each  opcode and shift amount to ALU.
REQ-009 SHALL: data_result  in  32; isNotEqual, isLessThan, overflow  in  1 each  ALU responses.
REQ-010 SHALL: busy, done, pass  out  1 each  run status.
REQ-011 SHALL: signature  out  32  current MISR value; vec_count  out  16  vectors captured this run.

Function
REQ-012 SHALL: FSM states IDLE, DRIVE, CAPTURE, DONE; IDLE->DRIVE on start (num_vectors>0), IDLE->DONE on start (num_vectors==0).
REQ-013 SHALL: DRIVE->CAPTURE unconditionally; CAPTURE->DRIVE if vec_count+1<num_vectors, else CAPTURE->DONE; each vector takes exactly 2 cycles.
REQ-014 SHALL: operands registered; ALU outputs sampled in CAPTURE, one cycle after operands change.
REQ-015 SHALL: A from LFSR-A, seed 0xACE12345; B from LFSR-B, seed 0x13579BDF; both Galois, poly 0x80200003, advance once per CAPTURE.
REQ-016 SHALL: ctrl_shiftamt = B[4:0]; opcode cycles 0 ADD,1 SUB,2 AND,3 OR,4 SLL,5 SRA by vec_count mod 6.
REQ-017 SHALL: flag word = {overflow masked unless op 0/1, isLessThan masked unless op 1, isNotEqual masked unless op 1} in bits [2:0], zero elsewhere.
REQ-018 SHALL: MISR seed 0xFFFFFFFF; per CAPTURE sig = (sig<<1) ^ (sig[31]?0x80200003:0) ^ data_result ^ flag word.
REQ-019 SHALL: on entering DONE, done=1, busy=0, pass=(signature==golden_sig latched); outputs hold until next accepted start.
REQ-020 SHALL: start while busy ignored; start in DONE reseeds LFSRs/MISR, clears vec_count/done/pass, re-samples inputs.
REQ-021 SHALL: abort in any state -> IDLE next cycle, done=0, pass=0, busy=0; abort wins over simultaneous start.
REQ-022 SHALL: busy=1 exactly in DRIVE and CAPTURE; vec_count saturates at num_vectors, never wraps.
REQ-023 SHALL: num_vectors=0xFFFF completes 0xFFFF vectors with no counter overflow.

Reset
REQ-024 SHALL: reset low forces IDLE, operands 0, opcode 0, shiftamt 0, signature 0xFFFFFFFF, vec_count 0, busy/done/pass 0, asynchronously.
REQ-025 SHALL: reset asserted mid-run discards the run; no done pulse follows deassertion.

Structure
REQ-026 SHALL: package alu_bist_pkg holds opcode constants, LFSR/MISR poly, seeds, FSM state encoding.
REQ-027 SHALL: sub-module bist_lfsr32 (load, seed, advance) instantiated twice for A and B; MISR and FSM in alu_bist.

Verification
REQ-028 SHALL: num_vectors=0, golden 0xFFFFFFFF, start -> done=1 and pass=1 one cycle later, busy never 1.
REQ-029 SHALL: num_vectors=1 with real alu -> A=0xACE12345, B=0x13579BDF, op 0, shamt 0x1F; captured result 0xC038BF24, OVF 0; done after 2 cycles.
REQ-030 SHALL: num_vectors=12, golden from bench model -> pass=1; fault-injected ALU (result bit 0 stuck-at-0) -> pass=0.
REQ-031 SHALL: abort asserted during vector 5 of 12 -> IDLE next cycle, done=0; then start -> full fresh run, same signature as undisturbed run.
REQ-032 SHALL: reset pulse mid-run -> all outputs at reset values immediately; start ignored while busy confirmed by unchanged vec_count sequence.
